// File: rtl/led_sequencer.sv
// Multi-channel status LED pattern generator: rotate/blink/bounce/count patterns,
// stepped by a speed-selectable prescaler, gated by a global PWM brightness.
module led_sequencer #(
    parameter int CLK_HZ     = 24_000_000,
    parameter int NUM_LEDS   = 3,
    parameter int STEP_MS    = 250,
    parameter int PWM_BITS   = 8,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [1:0]          mode,
    input  logic [1:0]          speed,
    input  logic                pause,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [NUM_LEDS-1:0] led,
    output logic                step_tick
);

    localparam int STEP_CYCLES = CLK_HZ / 1000 * STEP_MS;
    localparam int CNT_W       = $clog2(STEP_CYCLES + 1);
    localparam logic [31:0] STEP_LIM = 32'(STEP_CYCLES);

    localparam logic [1:0] MODE_ROTATE = 2'b00;
    localparam logic [1:0] MODE_BLINK  = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_COUNT  = 2'b11;

    localparam logic [NUM_LEDS-1:0] PAT_FIRST = NUM_LEDS'(1);
    localparam logic [NUM_LEDS-1:0] LED_OFF   = ACTIVE_LOW ? '1 : '0;

    logic [CNT_W-1:0]    prescaler;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [1:0]          mode_q;
    logic [NUM_LEDS-1:0] pat;
    logic                dir;
    logic [31:0]         limit;
    logic                tick_p0;
    logic                pwm_on_p0;
    logic [NUM_LEDS-1:0] lit_p0;
    logic [NUM_LEDS-1:0] pat_nxt;
    logic                dir_nxt;

    function automatic logic [NUM_LEDS-1:0] init_pat(input logic [1:0] m);
        case (m)
            MODE_BLINK: init_pat = '1;
            MODE_COUNT: init_pat = '0;
            default:    init_pat = PAT_FIRST;
        endcase
    endfunction

    // A limit of 0 or 1 both mean a tick every cycle; LIMIT-1 must not underflow.
    assign limit   = STEP_LIM >> speed;
    assign tick_p0 = !pause && ((limit <= 32'd1) || (32'(prescaler) >= (limit - 32'd1)));

    assign pwm_on_p0 = (&brightness) || (pwm_cnt < brightness);
    assign lit_p0    = pat & {NUM_LEDS{pwm_on_p0}};

    always_comb begin
        pat_nxt = pat;
        dir_nxt = dir;
        if (mode != mode_q) begin
            pat_nxt = init_pat(mode);
            dir_nxt = 1'b1;
        end else begin
            case (mode_q)
                MODE_ROTATE: pat_nxt = {pat[NUM_LEDS-2:0], pat[NUM_LEDS-1]};
                MODE_BLINK:  pat_nxt = ~pat;
                MODE_BOUNCE: begin
                    // dir flips as the one-hot lands on an end bit, so each end shows once.
                    if (dir) begin
                        pat_nxt = pat << 1;
                        dir_nxt = ~pat[NUM_LEDS-2];
                    end else begin
                        pat_nxt = pat >> 1;
                        dir_nxt = pat[1];
                    end
                end
                default:     pat_nxt = pat + NUM_LEDS'(1);
            endcase
        end
    end

    // Stage boundary: prescaler/pattern/PWM state and the registered pin drive.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            prescaler <= '0;
            pwm_cnt   <= '0;
            step_tick <= 1'b0;
            mode_q    <= MODE_ROTATE;
            pat       <= PAT_FIRST;
            dir       <= 1'b1;
            led       <= LED_OFF;
        end else begin
            pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
            step_tick <= tick_p0;
            if (tick_p0) begin
                prescaler <= '0;
                pat       <= pat_nxt;
                dir       <= dir_nxt;
                mode_q    <= mode;
            end else if (!pause) begin
                prescaler <= prescaler + CNT_W'(1);
            end
            led <= ACTIVE_LOW ? ~lit_p0 : lit_p0;
        end
    end

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer: expected (gap, led) pairs are queued per step
// and checked by a monitor one cycle after each step_tick.
module tb_led_sequencer;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic [1:0] mode;
    logic [1:0] speed;
    logic       pause;
    logic [1:0] brightness;
    logic [2:0] led;
    logic       step_tick;
    logic [2:0] led_b;
    logic       tick_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         gap;
        logic [2:0] led;
    } exp_t;
    exp_t sb_q[$];

    int   mon_cyc  = 0;
    int   mon_pend = 0;
    bit   mon_tick = 1'b0;
    exp_t mon_e;

    always #5 sys_clk = ~sys_clk;

    led_sequencer #(
        .CLK_HZ(1000), .NUM_LEDS(3), .STEP_MS(4), .PWM_BITS(2), .ACTIVE_LOW(1'b1)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .mode(mode), .speed(speed),
        .pause(pause), .brightness(brightness), .led(led), .step_tick(step_tick)
    );

    led_sequencer #(
        .CLK_HZ(1000), .NUM_LEDS(3), .STEP_MS(4), .PWM_BITS(2), .ACTIVE_LOW(1'b0)
    ) dut_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .mode(mode), .speed(speed),
        .pause(pause), .brightness(brightness), .led(led_b), .step_tick(tick_b)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic push(input int gap, input logic [2:0] l);
        exp_t e;
        e.gap = gap;
        e.led = l;
        sb_q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge sys_clk);
            #1;
            n++;
        end
        check(name, sb_q.size(), 0);
        sb_q.delete();
    endtask

    // Monitor: gap is counted in cycles between step_tick pulses; led is checked one
    // cycle after the tick because the pin lags the pattern by a register.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (mon_tick) begin
                check("tick_expected", (sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    mon_e = sb_q.pop_front();
                    check("tick_led", led, mon_e.led);
                    if (mon_e.gap != 0) check("tick_gap", mon_pend, mon_e.gap);
                end
            end
            if (!sys_rst_n) mon_cyc = 0;
            else            mon_cyc++;
            if (step_tick) begin
                mon_pend = mon_cyc;
                mon_cyc  = 0;
            end
            mon_tick = step_tick;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int on_cnt;
        int bad_cnt;
        sys_rst_n  = 1'b0;
        mode       = 2'b00;
        speed      = 2'b00;
        pause      = 1'b0;
        brightness = 2'b11;
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_led", led, 3'b111);
        check("rst_tick", step_tick, 0);

        // ROTATE at speed 0
        push(0, 3'b101); push(4, 3'b011); push(4, 3'b110); push(4, 3'b101);
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        check("init_led", led, 3'b110);
        wait_drain("rotate_drain");

        // BOUNCE then COUNT, each starting with a mode-change tick
        mode = 2'b10;
        push(4, 3'b110); push(4, 3'b101); push(4, 3'b011);
        push(4, 3'b101); push(4, 3'b110); push(4, 3'b101);
        wait_drain("bounce_drain");
        mode = 2'b11;
        push(4, 3'b111); push(4, 3'b110); push(4, 3'b101); push(4, 3'b100); push(4, 3'b011);
        push(4, 3'b010); push(4, 3'b001); push(4, 3'b000); push(4, 3'b111);
        wait_drain("count_drain");

        // prescaler is 2 here: speed 3 ticks next cycle then every cycle; speed 1 every 2
        push(3, 3'b110); push(1, 3'b101); push(1, 3'b100); push(1, 3'b011);
        push(2, 3'b010); push(2, 3'b001); push(2, 3'b000);
        speed = 2'd3;
        repeat (4) @(posedge sys_clk);
        #1;
        speed = 2'd1;
        repeat (6) @(posedge sys_clk);
        #1;
        speed = 2'd0;
        mode  = 2'b00;
        push(4, 3'b110); push(4, 3'b101);
        wait_drain("speed_drain");

        // pause mid-ROTATE with prescaler at 2, pat = 010
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge sys_clk);
            #1;
            check("pause_tick", step_tick, 0);
            check("pause_led", led, 3'b101);
        end

        // brightness sweep while paused: PWM keeps running
        brightness = 2'd1;
        on_cnt = 0; bad_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge sys_clk);
            #1;
            if (led == 3'b101) on_cnt++;
            else if (led != 3'b111) bad_cnt++;
        end
        check("pwm1_on", on_cnt, 2);
        check("pwm1_bad", bad_cnt, 0);
        brightness = 2'd0;
        on_cnt = 0; bad_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge sys_clk);
            #1;
            if (led == 3'b101) on_cnt++;
            else if (led != 3'b111) bad_cnt++;
        end
        check("pwm0_on", on_cnt, 0);
        check("pwm0_bad", bad_cnt, 0);
        brightness = 2'd3;
        on_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge sys_clk);
            #1;
            if (led == 3'b101) on_cnt++;
        end
        check("pwm3_on", on_cnt, 8);

        // release: prescaler resumes at 2, so the tick comes two cycles later
        push(0, 3'b011);
        pause = 1'b0;
        @(posedge sys_clk);
        #1;
        check("resume_tick_early", step_tick, 0);
        @(posedge sys_clk);
        #1;
        check("resume_tick", step_tick, 1);

        // reset mid-BOUNCE (pat 100, heading down)
        mode = 2'b10;
        push(4, 3'b110); push(4, 3'b101); push(4, 3'b011);
        wait_drain("bounce2_drain");
        sys_rst_n = 1'b0;
        mode      = 2'b00;
        push(0, 3'b101);
        @(posedge sys_clk);
        #1;
        check("rst_b_led", led_b, 3'b000);
        check("rst_b_tick", tick_b, 0);
        check("rst_a_led", led, 3'b111);
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        check("post_rst_b_led", led_b, 3'b001);
        wait_drain("post_rst_drain");
        check("post_tick_b_led", led_b, 3'b010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
